// File: rtl/ham_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ham_pkg
//  Purpose  : Shared types and constants for the Hamming min/max engine.
//             State encoding, operand/distance widths and the byte layout of
//             the operand and result regions in data memory.
//  Ports    : none (package)
//  Options  : PAIR_ADDR_EN enables the four WR_P* pair-index write states.
//  Revision : 1.0  initial release
// ============================================================================
package ham_pkg;

  localparam int OP_W    = 16;  // operand width in bits
  localparam int DIST_W  = 5;   // wide enough for 0..16
  localparam int HAM_MAX = 16;  // largest possible distance of two operands
  localparam int IDX_W   = 5;   // operand index counters j/k

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LOAD    = 4'd1,
    COMPARE = 4'd2,
    WR_MIN  = 4'd3,
    WR_MAX  = 4'd4,
    WR_P0   = 4'd5,
    WR_P1   = 4'd6,
    WR_P2   = 4'd7,
    WR_P3   = 4'd8,
    DONE    = 4'd9
  } ham_state_e;

  // Result bytes carry a 5-bit value zero-extended to a full byte.
  function automatic logic [7:0] pad_byte(input logic [DIST_W-1:0] v);
    return {3'b000, v};
  endfunction

endpackage : ham_pkg
`default_nettype wire

// File: rtl/ham_dist16.sv
`default_nettype none
// ============================================================================
//  Module   : ham_dist16
//  Purpose  : Combinational Hamming distance of two 16-bit operands
//             (XOR followed by a population count).
//  Ports    : a_i    [15:0]  first operand
//             b_i    [15:0]  second operand
//             dist_o [4:0]   number of differing bit positions (0..16)
//  Revision : 1.0  initial release
// ============================================================================
module ham_dist16
  import ham_pkg::*;
(
  input  logic [OP_W-1:0]   a_i,
  input  logic [OP_W-1:0]   b_i,
  output logic [DIST_W-1:0] dist_o
);

  logic [OP_W-1:0] w_diff;

  always_comb begin
    w_diff = a_i ^ b_i;
    dist_o = '0;
    for (int i = 0; i < OP_W; i++) begin
      dist_o = dist_o + DIST_W'(w_diff[i]);
    end
  end

endmodule : ham_dist16
`default_nettype wire

// File: rtl/ham_minmax_engine.sv
`default_nettype none
// ============================================================================
//  Module   : ham_minmax_engine
//  Purpose  : Scans N_OPS 16-bit operands held in data-memory bytes
//             [0 .. 2*N_OPS-1], finds the minimum and maximum pairwise
//             Hamming distance and writes them to MIN_ADDR / MAX_ADDR.
//             Uses the core's start/done handshake: a falling edge of start
//             while idle launches a run, done stays high until start rises.
//  Ports    : clk      system clock, rising edge
//             reset    synchronous active-high reset
//             start    run request (falling edge launches)
//             done     run complete, held until start returns high
//             rd_addr  data-memory read address (synchronous read)
//             rd_data  read data, one cycle after rd_addr
//             wr_en    data-memory write strobe
//             wr_addr  data-memory write address
//             wr_data  data-memory write data
//             min_dist last computed minimum distance
//             max_dist last computed maximum distance
//  Options  : `define PAIR_ADDR_EN to also write the winning pair indices
//             (min_k, min_j, max_k, max_j) to PAIR_BASE .. PAIR_BASE+3.
//  Revision : 1.0  initial release
// ============================================================================
module ham_minmax_engine
  import ham_pkg::*;
#(
  parameter int N_OPS     = 32,  // j/k counters are IDX_W bits wide
  parameter int MIN_ADDR  = 64,
`ifdef PAIR_ADDR_EN
  parameter int PAIR_BASE = 66,
`endif
  parameter int MAX_ADDR  = 65
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  output logic [7:0]        rd_addr,
  input  logic [7:0]        rd_data,
  output logic              wr_en,
  output logic [7:0]        wr_addr,
  output logic [7:0]        wr_data,
  output logic [DIST_W-1:0] min_dist,
  output logic [DIST_W-1:0] max_dist
);

  localparam int             N_BYTES   = 2 * N_OPS;
  localparam logic [6:0]     LOAD_LAST = 7'(N_BYTES);      // capture of last byte
  localparam logic [6:0]     ADDR_LAST = 7'(N_BYTES - 1);  // last issued address
  localparam logic [IDX_W-1:0] J_LAST  = IDX_W'(N_OPS - 2);
  localparam logic [IDX_W-1:0] K_LAST  = IDX_W'(N_OPS - 1);

  ham_state_e state_q, state_d;

  logic                start_q;
  logic                armed_q;     // start has been seen high since reset
  logic [6:0]          cnt_q;       // LOAD cycle number 0..2*N_OPS
  logic [7:0]          rd_addr_q;
  logic [7:0]          cache_q [N_BYTES];
  logic [IDX_W-1:0]    j_q, k_q;
  logic [DIST_W-1:0]   run_min_q, run_max_q;
  logic [DIST_W-1:0]   min_dist_q, max_dist_q;
`ifdef PAIR_ADDR_EN
  logic [IDX_W-1:0]    min_j_q, min_k_q, max_j_q, max_k_q;
`endif

  logic                w_launch;
  logic [OP_W-1:0]     w_op_j, w_op_k;
  logic [DIST_W-1:0]   w_dist;

  // start_q alone resets high; armed_q additionally keeps a start line that
  // was never high since reset from looking like a falling edge.
  assign w_launch = (state_q == IDLE) && !start && start_q && armed_q;

  // Operand i lives in bytes 2i (high) and 2i+1 (low).
  assign w_op_j = {cache_q[{j_q, 1'b0}], cache_q[{j_q, 1'b1}]};
  assign w_op_k = {cache_q[{k_q, 1'b0}], cache_q[{k_q, 1'b1}]};

  ham_dist16 u_dist (
    .a_i    (w_op_j),
    .b_i    (w_op_k),
    .dist_o (w_dist)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // --------------------------------------------------------------------------
  // Next state and write-port outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    wr_en   = 1'b0;
    wr_addr = 8'h00;
    wr_data = 8'h00;
    unique case (state_q)
      IDLE: begin
        if (w_launch) state_d = LOAD;
      end
      LOAD: begin
        if (cnt_q == LOAD_LAST) state_d = COMPARE;
      end
      COMPARE: begin
        if ((j_q == J_LAST) && (k_q == K_LAST)) state_d = WR_MIN;
      end
      WR_MIN: begin
        wr_en   = 1'b1;
        wr_addr = 8'(MIN_ADDR);
        wr_data = pad_byte(run_min_q);
        state_d = WR_MAX;
      end
      WR_MAX: begin
        wr_en   = 1'b1;
        wr_addr = 8'(MAX_ADDR);
        wr_data = pad_byte(run_max_q);
`ifdef PAIR_ADDR_EN
        state_d = WR_P0;
`else
        state_d = DONE;
`endif
      end
`ifdef PAIR_ADDR_EN
      WR_P0: begin
        wr_en   = 1'b1;
        wr_addr = 8'(PAIR_BASE);
        wr_data = pad_byte(min_k_q);
        state_d = WR_P1;
      end
      WR_P1: begin
        wr_en   = 1'b1;
        wr_addr = 8'(PAIR_BASE + 1);
        wr_data = pad_byte(min_j_q);
        state_d = WR_P2;
      end
      WR_P2: begin
        wr_en   = 1'b1;
        wr_addr = 8'(PAIR_BASE + 2);
        wr_data = pad_byte(max_k_q);
        state_d = WR_P3;
      end
      WR_P3: begin
        wr_en   = 1'b1;
        wr_addr = 8'(PAIR_BASE + 3);
        wr_data = pad_byte(max_j_q);
        state_d = DONE;
      end
`endif
      DONE: begin
        done = 1'b1;
        if (start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand cache: byte c-1 arrives on LOAD cycle c. No reset needed, a run
  // always refills every byte before COMPARE reads it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if ((state_q == LOAD) && (cnt_q != 7'd0)) begin
      cache_q[6'(cnt_q - 7'd1)] <= rd_data;
    end
  end

  // --------------------------------------------------------------------------
  // Sequencing counters, running min/max and published results
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q    <= 1'b1;
      armed_q    <= 1'b0;
      cnt_q      <= '0;
      rd_addr_q  <= '0;
      j_q        <= '0;
      k_q        <= IDX_W'(1);
      run_min_q  <= DIST_W'(HAM_MAX);
      run_max_q  <= '0;
      min_dist_q <= DIST_W'(HAM_MAX);
      max_dist_q <= '0;
`ifdef PAIR_ADDR_EN
      min_j_q    <= '0;
      min_k_q    <= '0;
      max_j_q    <= '0;
      max_k_q    <= '0;
`endif
    end else begin
      start_q <= start;
      if (start) armed_q <= 1'b1;

      unique case (state_q)
        IDLE: begin
          if (w_launch) begin
            cnt_q     <= '0;
            rd_addr_q <= '0;
            j_q       <= '0;
            k_q       <= IDX_W'(1);
            run_min_q <= DIST_W'(HAM_MAX);
            run_max_q <= '0;
`ifdef PAIR_ADDR_EN
            min_j_q   <= '0;
            min_k_q   <= '0;
            max_j_q   <= '0;
            max_k_q   <= '0;
`endif
          end
        end
        LOAD: begin
          cnt_q <= cnt_q + 7'd1;
          // Address tracks the cycle number; it parks on the last byte.
          if (cnt_q < ADDR_LAST) rd_addr_q <= rd_addr_q + 8'd1;
        end
        COMPARE: begin
          // Strict compares: the earliest pair in scan order keeps a tie.
          if (w_dist < run_min_q) begin
            run_min_q <= w_dist;
`ifdef PAIR_ADDR_EN
            min_j_q   <= j_q;
            min_k_q   <= k_q;
`endif
          end
          if (w_dist > run_max_q) begin
            run_max_q <= w_dist;
`ifdef PAIR_ADDR_EN
            max_j_q   <= j_q;
            max_k_q   <= k_q;
`endif
          end
          if (k_q == K_LAST) begin
            j_q <= j_q + IDX_W'(1);
            k_q <= j_q + IDX_W'(2);
          end else begin
            k_q <= k_q + IDX_W'(1);
          end
        end
        default: ;
      endcase

      // Published results change only when a run reaches DONE.
      if ((state_d == DONE) && (state_q != DONE)) begin
        min_dist_q <= run_min_q;
        max_dist_q <= run_max_q;
      end
    end
  end

  assign rd_addr  = rd_addr_q;
  assign min_dist = min_dist_q;
  assign max_dist = max_dist_q;

endmodule : ham_minmax_engine
`default_nettype wire

// File: tb/tb_ham_minmax_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ham_minmax_engine
//  Purpose  : Directed self-checking bench for ham_minmax_engine with a
//             behavioural synchronous-read data memory.
//             Build with +define+PAIR_ADDR_EN to also check pair bytes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ham_minmax_engine;

`ifdef PAIR_ADDR_EN
  localparam int C_LAT   = 567;
  localparam int C_N_WR  = 6;
`else
  localparam int C_LAT   = 563;
  localparam int C_N_WR  = 2;
`endif
  localparam int C_BOUND = 800;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       done;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [4:0] min_dist;
  logic [4:0] max_dist;

  logic [7:0] mem  [256];   // operand bytes, written by the bench only
  logic [7:0] wmem [256];   // last value the DUT wrote per address
  int         wcnt [256];   // DUT writes per address
  int         n_wr = 0;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  ham_minmax_engine dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .done     (done),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .min_dist (min_dist),
    .max_dist (max_dist)
  );

  always @(posedge clk) begin
    rd_data <= mem[rd_addr];
    if (wr_en) begin
      wmem[wr_addr] <= wr_data;
      wcnt[wr_addr] <= wcnt[wr_addr] + 1;
      n_wr          <= n_wr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void set_op(input int i, input logic [15:0] v);
    mem[2*i]   = v[15:8];
    mem[2*i+1] = v[7:0];
  endfunction

  function automatic logic [15:0] get_op(input int i);
    return {mem[2*i], mem[2*i+1]};
  endfunction

  // Reference scan: strict < / > so the first pair in order wins a tie.
  task automatic model(output logic [4:0] mn, output logic [4:0] mx,
                       output logic [4:0] mnj, output logic [4:0] mnk,
                       output logic [4:0] mxj, output logic [4:0] mxk);
    int d;
    mn = 5'd16; mx = 5'd0; mnj = 0; mnk = 0; mxj = 0; mxk = 0;
    for (int j = 0; j < 32; j++) begin
      for (int k = j + 1; k < 32; k++) begin
        d = $countones(get_op(j) ^ get_op(k));
        if (d < int'(mn)) begin mn = 5'(d); mnj = 5'(j); mnk = 5'(k); end
        if (d > int'(mx)) begin mx = 5'(d); mxj = 5'(j); mxk = 5'(k); end
      end
    end
  endtask

  // Called between posedges with the DUT idle. Optionally wiggles start
  // mid-run, which must not disturb anything.
  task automatic do_run(input string tag, input bit toggle,
                        input logic [4:0] emin, input logic [4:0] emax,
                        input logic [4:0] emnj, input logic [4:0] emnk,
                        input logic [4:0] emxj, input logic [4:0] emxk);
    int  n;
    int  w0;
    bit  got;
    n = 0; got = 0;
    start = 1'b1;
    @(posedge clk); #1;
    w0 = n_wr;
    start = 1'b0;
    while (n < C_BOUND && !got) begin
      @(posedge clk); #1;
      n++;
      if (toggle && n == 150) start = 1'b1;
      if (toggle && n == 153) start = 1'b0;
      if (done) got = 1;
    end
    check({tag, " latency"}, n - 1, C_LAT);
    check({tag, " mem64"},   wmem[64], {3'b0, emin});
    check({tag, " mem65"},   wmem[65], {3'b0, emax});
    check({tag, " min_dist"}, min_dist, emin);
    check({tag, " max_dist"}, max_dist, emax);
    check({tag, " writes"},  n_wr - w0, C_N_WR);
`ifdef PAIR_ADDR_EN
    check({tag, " min_k"}, wmem[66], {3'b0, emnk});
    check({tag, " min_j"}, wmem[67], {3'b0, emnj});
    check({tag, " max_k"}, wmem[68], {3'b0, emxk});
    check({tag, " max_j"}, wmem[69], {3'b0, emxj});
`else
    if (emnj == emnk && emxj == emxk && emnj != emxj) $display("note: degenerate pairs");
`endif
    check({tag, " done held"}, done, 1'b1);
    start = 1'b1;
    @(posedge clk); #1;
    check({tag, " done falls"}, done, 1'b0);
  endtask

  logic [4:0] m_mn, m_mx, m_mnj, m_mnk, m_mxj, m_mxk;
  bit         saw_done;

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    reset = 1'b1;
    start = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst done",     done,     1'b0);
    check("rst wr_en",    wr_en,    1'b0);
    check("rst rd_addr",  rd_addr,  8'd0);
    check("rst wr_addr",  wr_addr,  8'd0);
    check("rst wr_data",  wr_data,  8'd0);
    check("rst min_dist", min_dist, 5'd16);
    check("rst max_dist", max_dist, 5'd0);

    // start held low out of reset must not launch
    reset = 1'b0;
    saw_done = 0;
    for (int c = 0; c < 650; c++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1;
    end
    check("held0 done", saw_done, 1'b0);
    check("held0 writes", n_wr, 0);

    // Pattern 1: 0x0000, 0xFFFF, rest 0x00FF -> min 0 at (2,3), max 16 at (0,1)
    set_op(0, 16'h0000);
    set_op(1, 16'hFFFF);
    for (int i = 2; i < 32; i++) set_op(i, 16'h00FF);
    do_run("p1", 1'b0, 5'd0, 5'd16, 5'd2, 5'd3, 5'd0, 5'd1);

    // Pattern 2: all equal -> min 0 at (0,1), max stays 0 at (0,0); start toggled mid-run
    for (int i = 0; i < 32; i++) set_op(i, 16'hA5A5);
    do_run("p2", 1'b1, 5'd0, 5'd0, 5'd0, 5'd1, 5'd0, 5'd0);

    // Pattern 3: random operands against the reference scan
    for (int i = 0; i < 32; i++) set_op(i, 16'($urandom));
    model(m_mn, m_mx, m_mnj, m_mnk, m_mxj, m_mxk);
    do_run("rnd", 1'b0, m_mn, m_mx, m_mnj, m_mnk, m_mxj, m_mxk);

    // Abort by reset during COMPARE, then relaunch
    for (int i = 0; i < 32; i++) set_op(i, 16'($urandom));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (1 + 65 + 200) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    begin
      int w0;
      w0 = n_wr;
      saw_done = done;
      for (int c = 0; c < 650; c++) begin
        @(posedge clk); #1;
        if (done) saw_done = 1;
      end
      check("abort done", saw_done, 1'b0);
      check("abort writes", n_wr - w0, 0);
    end
    model(m_mn, m_mx, m_mnj, m_mnk, m_mxj, m_mxk);
    do_run("relaunch", 1'b0, m_mn, m_mx, m_mnj, m_mnk, m_mxj, m_mxk);

`ifndef PAIR_ADDR_EN
    check("pair bytes untouched", wcnt[66] + wcnt[67] + wcnt[68] + wcnt[69], 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_ham_minmax_engine
`default_nettype wire
